// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types, constants and helpers for the MM:SS countdown
//                timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Width of a counter that must hold the values 0..ticks inclusive.
  function automatic int blink_cnt_width(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

  // Saturate an out-of-range preset digit to the largest legal value.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_dec.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_dec
//  Description : One stage of a BCD down-counter borrow chain. Wraps 0 -> MAX
//                and raises borrow_out when a borrow arrives at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_dec #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Decrement only when a borrow arrives; zero wraps to MAX and passes it on.
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Four-digit BCD MM:SS countdown timer with load/start/pause
//                commands, a one-cycle done pulse and a post-expiry blink.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int BLINK_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       cmd_load,
  input  logic       cmd_start,
  input  logic       cmd_pause,
  input  logic [3:0] preset_d3,
  input  logic [3:0] preset_d2,
  input  logic [3:0] preset_d1,
  input  logic [3:0] preset_d0,
  output logic [3:0] content_3,
  output logic [3:0] content_2,
  output logic [3:0] content_1,
  output logic [3:0] content_0,
  output logic       disp_en,
  output logic       done,
  output logic       running
);

  localparam int                 BLINK_W    = blink_cnt_width(BLINK_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS);

  timer_state_t       state_q, state_d;
  logic [3:0][3:0]    dig_q, dig_d;       // [0]=sec ones .. [3]=min tens
  logic [3:0][3:0]    dig_dec;
  logic [3:0][3:0]    preset_cl;
  logic [4:0]         borrow;
  logic [BLINK_W-1:0] blink_q, blink_d, blink_inc;
  logic               disp_en_q, disp_en_d;
  logic               done_q, done_d;
  logic               running_q, running_d;
  logic               count_zero;

  assign preset_cl[3] = clamp_digit(preset_d3, BCD_MAX);
  assign preset_cl[2] = clamp_digit(preset_d2, BCD_MAX);
  assign preset_cl[1] = clamp_digit(preset_d1, SEC_TENS_MAX);
  assign preset_cl[0] = clamp_digit(preset_d0, BCD_MAX);

  assign count_zero = (dig_q == '0);
  assign blink_inc  = blink_q + BLINK_W'(1);

  // Borrow chain: a tick enters at sec ones. A borrow leaving min tens means
  // the count was 00:00, and that result is discarded so it never wraps.
  assign borrow[0] = tick_1hz;
  for (genvar i = 0; i < 4; i++) begin : g_chain
    localparam logic [3:0] DMAX = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
    bcd_digit_dec #(.MAX(DMAX)) u_dec (
      .digit      (dig_q[i]),
      .borrow_in  (borrow[i]),
      .digit_next (dig_dec[i]),
      .borrow_out (borrow[i+1])
    );
  end

  // Next-state logic: load overrides everything, then per-state command handling.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    blink_d   = blink_q;
    disp_en_d = disp_en_q;
    done_d    = 1'b0;
    if (cmd_load) begin
      dig_d     = preset_cl;
      state_d   = IDLE;
      disp_en_d = 1'b1;
      blink_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cmd_pause && cmd_start && !count_zero) state_d = RUN;
        end
        RUN: begin
          if (cmd_pause) begin
            state_d = PAUSED;
          end else if (tick_1hz && !borrow[4]) begin
            dig_d = dig_dec;
            if (dig_dec == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!cmd_pause && cmd_start) state_d = RUN;
        end
        DONE: begin
          if (tick_1hz) begin
            disp_en_d = ~disp_en_q;
            blink_d   = blink_inc;
            if (blink_inc == BLINK_LAST) begin
              state_d   = IDLE;
              disp_en_d = 1'b1;
              blink_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  // State, digit and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dig_q     <= '0;
      blink_q   <= '0;
      disp_en_q <= 1'b1;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      blink_q   <= blink_d;
      disp_en_q <= disp_en_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign content_3 = dig_q[3];
  assign content_2 = dig_q[2];
  assign content_1 = dig_q[1];
  assign content_0 = dig_q[0];
  assign disp_en   = disp_en_q;
  assign done      = done_q;
  assign running   = running_q;

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD MM:SS countdown timer feeding the 7-segment display driver. It holds a loadable preset and decrements once per 1 Hz strobe while running. Its four digit outputs and display-enable wire directly to the display stage's `content_0..3` and `en` inputs. On expiry it pulses `done` and blinks the display for a fixed number of ticks.

## Interface
Parameters:
- `BLINK_TICKS`, default 6: number of 1 Hz ticks spent in DONE (display toggles once per tick).

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: single-cycle strobe, once per second, synchronous to `clk`.
- `cmd_load` in 1: single-cycle pulse; copy preset into the count.
- `cmd_start` in 1: single-cycle pulse; start or resume counting.
- `cmd_pause` in 1: single-cycle pulse; freeze the count.
- `preset_d3..preset_d0` in 4 each: preset digits, ordered min tens, min ones, sec tens, sec ones.
- `content_3..content_0` out 4 each: current BCD digits, ordered min tens, min ones, sec tens, sec ones.
- `disp_en` out 1: display enable.
- `done` out 1: one-cycle pulse on reaching 00:00.
- `running` out 1: high in RUN.

## Operation
- **States:** IDLE, RUN, PAUSED, DONE.
- **Command priority:** `cmd_load` > `cmd_pause` > `cmd_start` > `tick_1hz`. At most one action per cycle.
- **Load (any state):** count <= clamped preset, state <= IDLE, `disp_en` <= 1, blink counter cleared.
- **Preset clamp:** digits >9 load as 9; `preset_d1` >5 loads as 5.
- **IDLE:**
  - `cmd_start` with count != 00:00 -> RUN.
  - `cmd_start` with count == 00:00 is ignored.
  - Ticks are ignored.
- **RUN:**
  - `tick_1hz` decrements the count by one second (BCD borrow rules below).
  - If the pre-decrement count is 00:01, the count becomes 00:00, state -> DONE, and `done` = 1 for exactly that cycle.
  - `cmd_pause` -> PAUSED.
- **PAUSED:** ticks are ignored; `cmd_start` -> RUN; count is held.
- **DONE:**
  - Each tick toggles `disp_en` and increments the blink counter.
  - When the counter reaches `BLINK_TICKS`, state -> IDLE with `disp_en` forced to 1.
  - `cmd_start` and `cmd_pause` are ignored.
- **BCD decrement rules:**
  - sec ones: 0 -> 9 with borrow.
  - sec tens: 0 -> 5 with borrow.
  - min ones: 0 -> 9 with borrow.
  - min tens: decrements on borrow.
  - 00:00 is never decremented; there is no wrap to 99:59.
- `running` = (state == RUN).

## Timing
- All outputs are registered.
- **Reset values:**
  - `content_*` = 0.
  - `disp_en` = 1.
  - `done` = 0, `running` = 0.
  - State = IDLE, blink counter = 0.
- **Latency:**
  - A tick, command or load sampled at edge N is visible on the outputs after edge N.
  - `cmd_start` sampled at edge N -> `running` high after edge N; the first decrement occurs on the next tick, no earlier than edge N+1.
- **Simultaneous events:**
  - `cmd_pause` and tick in the same RUN cycle: no decrement, enter PAUSED.
  - `cmd_start` and tick in the same IDLE cycle: enter RUN, no decrement that cycle.
  - `cmd_load` and tick: load wins; no decrement, no `done`.
- **Reset mid-operation** (any state, including DONE with `disp_en` = 0): outputs return immediately and asynchronously to reset values; the preset is not reloaded.
- `done` never asserts for two consecutive cycles.

## Structure
- Shared package `timer_pkg`:
  - state enum `timer_state_t` (IDLE, RUN, PAUSED, DONE);
  - constants `BCD_MAX = 4'd9`, `SEC_TENS_MAX = 4'd5`;
  - width of the blink counter, sized by `$clog2(BLINK_TICKS+1)`.
- Sub-module `bcd_digit_dec`: parameter `MAX`; inputs digit and borrow-in; outputs next digit and borrow-out. Instantiated four times in a borrow chain.
- The top level holds the FSM, digit registers, blink counter and command priority logic.

## Test plan
- Reset, then load presets 1,2,5,9 -> contents show 1,2,5,9 (12:59), state IDLE, `disp_en` = 1, `running` = 0.
- Load 10:00, start, apply 1 tick -> 09:59. After 599 further ticks -> 00:00 with `done` high for exactly one cycle, state DONE.
- In DONE with `BLINK_TICKS` = 6, apply 6 ticks -> `disp_en` sequence 0,1,0,1,0,1; then state IDLE, `disp_en` = 1, count holds 00:00. A subsequent `cmd_start` is ignored.
- RUN at 00:30, assert `cmd_pause` in the same cycle as a tick -> count stays 00:30. Apply 3 further ticks -> unchanged. `cmd_start`, then 1 tick -> 00:29.
- Load preset digits 12,15,7,11 -> count loads as 9,9:5,9 (99:59). `cmd_load` with a simultaneous tick while in RUN -> count equals preset, state IDLE.
- Assert `rst_n` low in RUN at 05:00 mid-cycle -> `content_*` = 0 and `running` = 0 immediately without a clock edge. After release, `cmd_start` is ignored because the count is 00:00.
